// File: rtl/div.sv
// IEEE-754 single-precision divider: multi-cycle FSM with radix-2 restoring
// mantissa division, round-to-nearest-even, denormal inputs/outputs flushed.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_stb,
  output logic        busy,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, SPECIAL, DIVIDE, NORMALISE, ROUND, PACK, DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d, m_q, m_d;
  logic signed [9:0]  ze_q, ze_d;
  logic [26:0]        quo_q, quo_d;
  logic [25:0]        rem_q, rem_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        spec_z_q, spec_z_d, z_q, z_d;
  logic               special_q, special_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic is_nan, is_inf, is_zero, is_special;
  logic rup;
  logic [24:0] rsum;

  // Exponent 0 (including denormals) is treated as zero.
  assign a_zero  = (ea_q == 8'd0);
  assign b_zero  = (eb_q == 8'd0);
  assign a_nan   = (ea_q == 8'hFF) && (ma_q[22:0] != 23'd0);
  assign b_nan   = (eb_q == 8'hFF) && (mb_q[22:0] != 23'd0);
  assign a_inf   = (ea_q == 8'hFF) && (ma_q[22:0] == 23'd0);
  assign b_inf   = (eb_q == 8'hFF) && (mb_q[22:0] == 23'd0);
  assign is_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign is_inf  = a_inf | b_zero;
  assign is_zero = a_zero | b_inf;
  assign is_special = is_nan | is_inf | is_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      sign_q    <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      m_q       <= '0;
      ze_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      spec_z_q  <= '0;
      special_q <= 1'b0;
      z_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      sign_q    <= sign_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      m_q       <= m_d;
      ze_q      <= ze_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      spec_z_q  <= spec_z_d;
      special_q <= special_d;
      z_q       <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (input_stb) state_d = UNPACK;
      UNPACK:    state_d = SPECIAL;
      SPECIAL:   state_d = is_special ? PACK : DIVIDE;
      DIVIDE:    if (cnt_q == 5'd26) state_d = NORMALISE;
      NORMALISE: state_d = ROUND;
      ROUND:     state_d = PACK;
      PACK:      state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;
    sa_d = sa_q;  sb_d = sb_q;  sign_d = sign_q;
    ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;  m_d = m_q;
    ze_d = ze_q;  quo_d = quo_q;  rem_d = rem_q;  cnt_d = cnt_q;
    sticky_d = sticky_q;  spec_z_d = spec_z_q;  special_d = special_q;
    z_d = z_q;
    rup  = quo_q[2] & (quo_q[1] | quo_q[0] | sticky_q | quo_q[3]);
    rsum = {1'b0, quo_q[26:3]} + {24'd0, rup};
    case (state_q)
      IDLE: if (input_stb) begin
        a_d = input_a;
        b_d = input_b;
      end
      UNPACK: begin
        sa_d = a_q[31];
        sb_d = b_q[31];
        ea_d = a_q[30:23];
        eb_d = b_q[30:23];
        ma_d = {(a_q[30:23] != 8'd0), a_q[22:0]};
        mb_d = {(b_q[30:23] != 8'd0), b_q[22:0]};
      end
      SPECIAL: begin
        sign_d    = sa_q ^ sb_q;
        ze_d      = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        rem_d     = {2'b00, ma_q};
        quo_d     = '0;
        cnt_d     = '0;
        special_d = is_special;
        if (is_nan)       spec_z_d = QNAN;
        else if (is_inf)  spec_z_d = {sa_q ^ sb_q, 8'hFF, 23'd0};
        else              spec_z_d = {sa_q ^ sb_q, 31'd0};
      end
      DIVIDE: begin
        // Remainder stays below 2*divisor, so 26 bits hold the shifted value.
        if (rem_q >= {2'b00, mb_q}) begin
          quo_d = {quo_q[25:0], 1'b1};
          rem_d = (rem_q - {2'b00, mb_q}) << 1;
        end else begin
          quo_d = {quo_q[25:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 5'd1;
      end
      NORMALISE: begin
        sticky_d = |rem_q;
        if (!quo_q[26]) begin
          quo_d = quo_q << 1;
          ze_d  = ze_q - 10'sd1;
        end
      end
      ROUND: begin
        if (rsum[24]) begin
          m_d  = rsum[24:1];
          ze_d = ze_q + 10'sd1;
        end else begin
          m_d  = rsum[23:0];
        end
      end
      PACK: begin
        if (special_q)              z_d = spec_z_q;
        else if (ze_q >= 10'sd255)  z_d = {sign_q, 8'hFF, 23'd0};
        else if (ze_q <= 10'sd0)    z_d = {sign_q, 31'd0};
        else                        z_d = {sign_q, ze_q[7:0], m_q[22:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    output_z_stb = (state_q == DONE);
    output_z     = z_q;
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the single-precision divider.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        input_stb = 1'b0;
  logic        busy;
  logic [31:0] output_z;
  logic        output_z_stb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_stb    (input_stb),
    .busy         (busy),
    .output_z     (output_z),
    .output_z_stb (output_z_stb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE; optionally pulse new operands at edge inj_at.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z, input int exp_lat, input int inj_at);
    int n;
    logic busy_ok;
    input_a   = a;
    input_b   = b;
    input_stb = 1'b1;
    @(posedge clk);
    #1 input_stb = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      #1;
      if (inj_at != 0 && n == inj_at) begin
        input_a   = 32'h3F800000;
        input_b   = 32'h40400000;
        input_stb = 1'b1;
      end else begin
        input_stb = 1'b0;
      end
      if (output_z_stb) break;
    end
    input_stb = 1'b0;
    check({tag, "_z"}, output_z, exp_z);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_after"}, {30'd0, output_z_stb, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_z", output_z, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op("div20_4", 32'h41A00000, 32'h40800000, 32'h40A00000, 32, 0);
    run_op("neg10_2", 32'hC1200000, 32'h40000000, 32'hC0A00000, 32, 0);
    run_op("one_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32, 0);
    run_op("x_0",     32'h40800000, 32'h00000000, 32'h7F800000, 3, 0);
    run_op("0_0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3, 0);
    run_op("nan_x",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3, 0);
    run_op("x_inf",   32'hC0000000, 32'h7F800000, 32'h80000000, 3, 0);
    run_op("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 32, 0);
    run_op("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 32, 0);

    // Busy-ignore: new operands pulsed at edge 5 must not disturb or requeue.
    run_op("ignore",  32'h41A00000, 32'h40800000, 32'h40A00000, 32, 5);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (output_z_stb) pulses++;
    end
    check("ignore_no_second", pulses, 0);

    // Reset mid-divide: abort with no pulse, then a clean operation.
    input_a   = 32'h41A00000;
    input_b   = 32'h40800000;
    input_stb = 1'b1;
    @(posedge clk);
    #1 input_stb = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_stb", {31'd0, output_z_stb}, 32'd0);
    check("abort_z", output_z, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (output_z_stb || busy) pulses++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (output_z_stb || busy) pulses++;
    end
    check("abort_quiet", pulses, 0);
    run_op("after_rst", 32'h40E00000, 32'h40000000, 32'h40600000, 32, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
